// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Brief    : TileLink-UL mapped 8N1 UART transmitter with a byte TX FIFO.
// Revision : 1.0 - initial release
// ============================================================================

typedef struct packed {
  logic [2:0]  a_opcode;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_valid;
} tilelink_a;

typedef struct packed {
  logic [2:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_error;
  logic        d_valid;
} tilelink_d;

module serial_tx #(
  parameter logic [31:0] addr_mask      = 32'hF000_0000,
  parameter logic [31:0] addr_tag       = 32'hC000_0000,
  parameter int          cycles_per_bit = 868,
  parameter int          fifo_depth     = 8
) (
  input  logic      clock,
  input  logic      reset_in_n,
  input  tilelink_a tick_tla,
  output tilelink_d bus_tld,
  output logic      tx_line,
  output logic      tx_busy
);

  localparam int PTR_W  = $clog2(fifo_depth) + 1;
  localparam int IDX_W  = PTR_W - 1;
  localparam int BAUD_W = $clog2(cycles_per_bit);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(cycles_per_bit - 1);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_GET         = 3'd4;
  localparam logic [2:0] OP_ACK         = 3'd0;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;
  logic [7:0]        mem [fifo_depth];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              sel;
  logic              is_get;
  logic              is_put;
  logic              txdata_wr;
  logic              push;
  logic [31:0]       status;
  logic              unused_bits;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PTR_W'(fifo_depth));
  assign empty     = (count == '0);
  assign sel       = tick_tla.a_valid && ((tick_tla.a_address & addr_mask) == addr_tag);
  assign is_get    = (tick_tla.a_opcode == OP_GET);
  assign is_put    = (tick_tla.a_opcode == OP_PUT_FULL) || (tick_tla.a_opcode == OP_PUT_PARTIAL);
  assign txdata_wr = sel && is_put && (tick_tla.a_address[3:2] == 2'd0) && tick_tla.a_mask[0];
  // Full comes from the registered count, so a same-cycle pop never rescues a push.
  assign push      = txdata_wr && !full;
  assign status    = {24'd0, 4'(count), 1'b0, tx_busy, empty, full};
  assign unused_bits = ^{tick_tla.a_data[31:8], tick_tla.a_mask[3:1]};

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[IDX_W-1:0]] <= tick_tla.a_data[7:0];
    end
  end

  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      bus_tld <= '0;
      wr_ptr  <= '0;
    end else begin
      bus_tld.d_valid  <= sel;
      bus_tld.d_opcode <= (sel && is_get) ? OP_ACK_DATA : OP_ACK;
      bus_tld.d_data   <= (sel && is_get && (tick_tla.a_address[3:2] == 2'd1)) ? status : '0;
      bus_tld.d_error  <= txdata_wr && full;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rd_ptr   <= '0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_busy <= (state != IDLE) || !empty;
      case (state)
        IDLE: begin
          tx_line <= 1'b1;
          if (!empty) begin
            shreg    <= mem[rd_ptr[IDX_W-1:0]];
            rd_ptr   <= rd_ptr + PTR_W'(1);
            baud_cnt <= '0;
            tx_line  <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_line  <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_line <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_line <= shreg[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when more data is waiting.
            if (!empty) begin
              shreg   <= mem[rd_ptr[IDX_W-1:0]];
              rd_ptr  <= rd_ptr + PTR_W'(1);
              tx_line <= 1'b0;
              state   <= START;
            end else begin
              tx_line <= 1'b1;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          tx_line <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx
// Brief    : Self-checking bench for serial_tx against a frame-schedule model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;
  localparam int LOG_N = 8192;

  localparam logic [2:0]  PUT_FULL = 3'd0;
  localparam logic [2:0]  PUT_PART = 3'd1;
  localparam logic [2:0]  GET      = 3'd4;
  localparam logic [31:0] TXDATA   = 32'hC000_0000;
  localparam logic [31:0] STATUS   = 32'hC000_0004;

  logic      clock = 1'b0;
  logic      reset_in_n = 1'b0;
  tilelink_a tick_tla;
  tilelink_d bus_tld;
  logic      tx_line;
  logic      tx_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic line_log [LOG_N];
  logic busy_log [LOG_N];

  // Model: every accepted byte with its push edge and the edge its frame starts.
  int         m_edge [$];
  int         m_start[$];
  logic [7:0] m_data [$];

  tilelink_d rsp;
  tilelink_d exp_rsp;
  int        rsp_edge;

  serial_tx #(
    .addr_mask     (32'hF000_0000),
    .addr_tag      (32'hC000_0000),
    .cycles_per_bit(CPB),
    .fifo_depth    (DEPTH)
  ) dut (
    .clock     (clock),
    .reset_in_n(reset_in_n),
    .tick_tla  (tick_tla),
    .bus_tld   (bus_tld),
    .tx_line   (tx_line),
    .tx_busy   (tx_busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Index c holds the value seen after rising edge number c.
  always @(negedge clock) begin
    if (cyc < LOG_N) begin
      line_log[cyc] = tx_line;
      busy_log[cyc] = tx_busy;
    end
  end

  function automatic int count_at(input int t);
    int n = 0;
    foreach (m_edge[i]) if (m_edge[i] <= t && m_start[i] > t) n++;
    return n;
  endfunction

  function automatic logic in_frame(input int t);
    logic r = 1'b0;
    foreach (m_start[i]) if (t >= m_start[i] && t < m_start[i] + FRAME) r = 1'b1;
    return r;
  endfunction

  function automatic logic busy_at(input int c);
    return in_frame(c - 1) || (count_at(c - 1) != 0);
  endfunction

  function automatic logic line_at(input int c);
    logic r = 1'b1;
    int   k;
    foreach (m_start[i]) begin
      if (c >= m_start[i] && c < m_start[i] + FRAME) begin
        k = (c - m_start[i]) / CPB;
        if (k == 0)      r = 1'b0;
        else if (k == 9) r = 1'b1;
        else             r = m_data[i][k-1];
      end
    end
    return r;
  endfunction

  function automatic logic model_push(input int n, input logic [7:0] d);
    int s;
    if (count_at(n - 1) >= DEPTH) return 1'b0;
    s = n + 1;
    if (m_start.size() > 0 && m_start[$] + FRAME > s) s = m_start[$] + FRAME;
    m_edge.push_back(n);
    m_start.push_back(s);
    m_data.push_back(d);
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_at(input int n);
    int c = count_at(n - 1);
    return {24'd0, 4'(c), 1'b0, busy_at(n - 1), (c == 0), (c == DEPTH)};
  endfunction

  function automatic tilelink_d model_access(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [3:0] mask, input logic [31:0] data,
                                             input int n);
    tilelink_d r = '0;
    if ((addr & 32'hF000_0000) == 32'hC000_0000) begin
      r.d_valid = 1'b1;
      if (op == GET) begin
        r.d_opcode = 3'd1;
        if (addr[3:2] == 2'd1) r.d_data = status_at(n);
      end else if ((op == PUT_FULL || op == PUT_PART) && addr[3:2] == 2'd0 && mask[0]) begin
        r.d_error = !model_push(n, data[7:0]);
      end
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_edge.delete();
    m_start.delete();
    m_data.delete();
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic access(input logic [2:0] op, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] data);
    tick_tla.a_opcode  = op;
    tick_tla.a_address = addr;
    tick_tla.a_mask    = mask;
    tick_tla.a_data    = data;
    tick_tla.a_valid   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    rsp      = bus_tld;
    rsp_edge = cyc;
    tick_tla.a_valid = 1'b0;
    exp_rsp  = model_access(op, addr, mask, data, rsp_edge);
  endtask

  task automatic test_reset;
    tick_tla = '0;
    idle(3);
    checks++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0 || bus_tld !== '0) begin
      errors++;
      $display("FAIL reset_hold: tx_line=%b tx_busy=%b d=%h, want 1 0 0", tx_line, tx_busy, bus_tld);
    end
    reset_in_n = 1'b1;
    idle(2);
    checks++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0 || bus_tld.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: tx_line=%b tx_busy=%b d_valid=%b, want 1 0 0",
               tx_line, tx_busy, bus_tld.d_valid);
    end
    access(GET, STATUS, 4'hF, 32'h0);
    checks++;
    if (rsp !== exp_rsp || rsp.d_data !== 32'h2) begin
      errors++;
      $display("FAIL reset_status: got %h want %h (d_data 2)", rsp, exp_rsp);
    end
  endtask

  task automatic test_single;
    int first;
    logic want;
    access(PUT_FULL, TXDATA, 4'hF, 32'h0000_0055);
    first = rsp_edge;
    checks++;
    if (rsp !== exp_rsp || rsp.d_valid !== 1'b1 || rsp.d_opcode !== 3'd0) begin
      errors++;
      $display("FAIL single_ack: got %h want %h", rsp, exp_rsp);
    end
    idle(FRAME + 6);
    for (int k = 0; k < 10; k++) begin
      want = k[0];
      checks++;
      if (line_log[first + 1 + k * CPB] !== want || line_log[first + CPB * (k + 1)] !== want) begin
        errors++;
        $display("FAIL single_bit%0d: tx_line=%b/%b want %b", k,
                 line_log[first + 1 + k * CPB], line_log[first + CPB * (k + 1)], want);
      end
    end
    for (int c = first; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL single_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  task automatic test_back_to_back;
    int s;
    access(PUT_FULL, TXDATA, 4'hF, 32'h0000_00A5);
    s = rsp_edge + 1;
    checks++;
    if (rsp !== exp_rsp) begin
      errors++;
      $display("FAIL b2b_ack0: got %h want %h", rsp, exp_rsp);
    end
    access(PUT_PART, TXDATA, 4'h1, 32'h0000_003C);
    checks++;
    if (rsp !== exp_rsp) begin
      errors++;
      $display("FAIL b2b_ack1: got %h want %h", rsp, exp_rsp);
    end
    idle(2 * FRAME + 6);
    checks++;
    if (line_log[s + FRAME] !== 1'b0 || busy_log[s + 2 * FRAME] !== 1'b1 ||
        busy_log[s + 2 * FRAME + 1] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_edges: start2=%b busy_end=%b busy_after=%b want 0 1 0",
               line_log[s + FRAME], busy_log[s + 2 * FRAME], busy_log[s + 2 * FRAME + 1]);
    end
    for (int c = s - 1; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL b2b_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  task automatic test_fill;
    int t0 = cyc + 1;
    int last;
    for (int i = 0; i < 10; i++) begin
      access(PUT_FULL, TXDATA, 4'hF, $urandom);
      checks++;
      if (rsp !== exp_rsp || rsp.d_error !== (i == 9)) begin
        errors++;
        $display("FAIL fill_write%0d: got %h want %h", i, rsp, exp_rsp);
      end
    end
    access(GET, STATUS, 4'hF, 32'h0);
    checks++;
    if (rsp !== exp_rsp || rsp.d_data !== 32'h85) begin
      errors++;
      $display("FAIL fill_status: got %h want %h (d_data 85)", rsp, exp_rsp);
    end
    last = m_start[$] + FRAME;
    idle(last + 3 - cyc);
    for (int c = t0; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL fill_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    int rel;
    logic [7:0] b0 = 8'($urandom) & 8'hF7;
    access(PUT_FULL, TXDATA, 4'hF, {24'd0, b0});
    s = rsp_edge + 1;
    access(PUT_FULL, TXDATA, 4'hF, $urandom);
    access(PUT_FULL, TXDATA, 4'hF, $urandom);
    idle(s + 4 * CPB + 1 - cyc);
    checks++;
    if (tx_line !== line_at(cyc) || tx_line !== 1'b0) begin
      errors++;
      $display("FAIL midreset_bit3: tx_line=%b want %b", tx_line, line_at(cyc));
    end
    #1 reset_in_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (tx_line !== 1'b1 || tx_busy !== 1'b0 || bus_tld.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: tx_line=%b tx_busy=%b d_valid=%b want 1 0 0",
               tx_line, tx_busy, bus_tld.d_valid);
    end
    idle(3);
    reset_in_n = 1'b1;
    rel = cyc;
    access(GET, STATUS, 4'hF, 32'h0);
    checks++;
    if (rsp !== exp_rsp || rsp.d_data !== 32'h2) begin
      errors++;
      $display("FAIL midreset_status: got %h want %h (d_data 2)", rsp, exp_rsp);
    end
    idle(3 * FRAME);
    for (int c = rel + 1; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL midreset_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  task automatic test_unselected;
    int t0 = cyc + 1;
    access(PUT_FULL, TXDATA, 4'hF, $urandom);
    checks++;
    if (rsp !== exp_rsp) begin
      errors++;
      $display("FAIL unsel_push: got %h want %h", rsp, exp_rsp);
    end
    access(PUT_FULL, 32'h8000_0000, 4'hF, $urandom);
    checks++;
    if (rsp !== exp_rsp || rsp.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL unsel_write: got %h want %h", rsp, exp_rsp);
    end
    access(GET, 32'h8000_0004, 4'hF, 32'h0);
    checks++;
    if (rsp !== exp_rsp || rsp.d_valid !== 1'b0) begin
      errors++;
      $display("FAIL unsel_read: got %h want %h", rsp, exp_rsp);
    end
    access(PUT_PART, TXDATA, 4'hE, $urandom);
    checks++;
    if (rsp !== exp_rsp || rsp.d_error !== 1'b0) begin
      errors++;
      $display("FAIL nomask_write: got %h want %h", rsp, exp_rsp);
    end
    access(GET, STATUS, 4'hF, 32'h0);
    checks++;
    if (rsp !== exp_rsp) begin
      errors++;
      $display("FAIL unsel_status: got %h want %h", rsp, exp_rsp);
    end
    idle(FRAME + 4);
    for (int c = t0; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL unsel_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  task automatic test_random;
    int t0 = cyc + 1;
    int last;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [3:0]  nib;
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 9);
      idle($urandom_range(0, 14));
      mask = 4'hF;
      addr = {4'hC, 24'($urandom), 4'($urandom_range(0, 3))};
      if (kind <= 5) begin
        op = ($urandom_range(0, 1) == 1) ? PUT_PART : PUT_FULL;
        addr[3:2] = 2'd0;
        if ($urandom_range(0, 4) == 0) mask = 4'hE;
      end else if (kind <= 7) begin
        op = GET;
        addr[3:2] = 2'd1;
      end else if (kind == 8) begin
        op = ($urandom_range(0, 1) == 1) ? GET : PUT_FULL;
        addr[3:2] = 2'($urandom_range(2, 3));
      end else begin
        op = ($urandom_range(0, 1) == 1) ? GET : PUT_FULL;
        nib = 4'($urandom_range(0, 14));
        if (nib >= 4'hC) nib = nib + 4'd1;
        addr[31:28] = nib;
      end
      access(op, addr, mask, $urandom);
      checks++;
      if (rsp !== exp_rsp) begin
        errors++;
        $display("FAIL random_rsp%0d op=%0d addr=%h: got %h want %h", i, op, addr, rsp, exp_rsp);
      end
    end
    last = (m_start.size() > 0) ? m_start[$] + FRAME : cyc;
    if (last + 3 > cyc) idle(last + 3 - cyc);
    for (int c = t0; c < cyc; c++) begin
      checks++;
      if (line_log[c] !== line_at(c) || busy_log[c] !== busy_at(c)) begin
        errors++;
        $display("FAIL random_line cycle %0d: tx_line=%b tx_busy=%b want %b %b",
                 c, line_log[c], busy_log[c], line_at(c), busy_at(c));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_reset_mid();
    test_unselected();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
